kronos_dmem_responder: RTL and testbench
========================================

Name: kronos_dmem_responder

Overview:
Memory-side responder for the Kronos data memory interface. It accepts aligned word requests from the core's load/store unit and models a single-port, byte-maskable data RAM with a programmable wait-state count. It returns a one-cycle data_ack with registered read data. It sits between the core's data port and on-chip SRAM, and also serves as the standard data-memory model in core testbenches.

Parameters:
DEPTH, 1024, number of 32-bit words (power of two, at least 4)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH*4-aligned)
WAIT_CYCLES, 0, extra cycles between request capture and ack (0..15)

Ports:
clk  in  1  clock
rstz  in  1  asynchronous active-low reset
data_addr  in  32  byte address from initiator; bits [1:0] ignored
data_rd_data  out  32  read word, valid in ack cycle, held until next ack
data_wr_data  in  32  write word, byte lanes aligned to address
data_mask  in  4  byte enables; used only for writes
data_wr_en  in  1  1 = write, 0 = read; sampled with data_req
data_req  in  1  request; initiator holds it until ack, drops it in the ack cycle
data_ack  out  1  single-cycle completion pulse

Behaviour:
- Reset (async, rstz low): state IDLE, data_ack 0, data_rd_data 32'h0, wait counter 0. RAM contents are not cleared. Reset mid-transaction abandons it; a write that has not reached commit is not performed.
- FSM states: IDLE, WAIT, ACK.
- IDLE: when data_req=1 at an edge, capture addr[31:2], wr_data, mask, and wr_en.
  - If WAIT_CYCLES=0, go to ACK.
  - Otherwise go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: counter decrements each cycle. When counter=0, go to ACK on the next edge.
- Latency: req first seen high in cycle T gives data_ack=1 in cycle T+1+WAIT_CYCLES, exactly one cycle. data_ack is a registered output; it is high only in ACK.
- Commit happens on the edge that enters ACK:
  - Write: RAM bytes with mask[i]=1 take wr_data[8i+7:8i]. Other bytes are unchanged. data_rd_data is unchanged.
  - Read: data_rd_data <= full RAM word. The mask is ignored.
- ACK to IDLE unconditionally. data_req is ignored while in ACK, because the initiator gates it low there.
  - Throughput is one transfer per WAIT_CYCLES+2 cycles.
  - A back-to-back request is captured in the cycle after ACK.
- Changes on data_req or its qualifiers after capture do not affect the captured transaction. There is no abort.
- Word index = (captured_addr - BASE_ADDR)[log2(DEPTH)+1:2]. This is a modulo wrap for out-of-range addresses, unless the optional feature is enabled.
- Read-after-write to the same word returns the new data: the write commits before the next request can be captured.
- A write with mask=4'b0000 still acks and modifies nothing.

Optional Feature:
KRONOS_DMEM_BUSERR_EN. When defined:
- Adds output port data_err (1 bit, reset 0), asserted together with data_ack whenever the captured address is outside [BASE_ADDR, BASE_ADDR+DEPTH*4).
- On error, writes are suppressed and data_rd_data <= 32'h0.
- In-range transfers drive data_err=0.

When undefined: no data_err port, and all addresses wrap modulo DEPTH.

Decomposition:
- kronos_types gets:
  - dmem_state_e enum {DMEM_IDLE, DMEM_WAIT, DMEM_ACK}
  - DMEM_WAIT_W=4 counter-width constant
- Natural sub-module kronos_dmem_array: DEPTH x 4-byte-lane synchronous RAM (one port, per-lane write enable, registered read). The responder FSM drives its enable, address, lane enables, and data.

Test Plan:
1. WAIT_CYCLES=0. Write 32'hDEADBEEF, mask 4'hF, to addr 0x10, then read 0x10. Required: ack is one cycle after each req, and data_rd_data=32'hDEADBEEF.
2. Masked write 32'h0000AA00, mask 4'b0010, to 0x10, then read. Required: data_rd_data=32'hDEADAAEF; a read with mask=4'h1 returns the same full word.
3. WAIT_CYCLES=3. Issue a read. Required: ack in cycle T+4 only; data_ack is never high for two cycles; data_rd_data is unchanged until the ack cycle.
4. Back-to-back: store 0x20 then load 0x20 with req re-raised the cycle after ack. Required: the load returns the stored value, with spacing of WAIT_CYCLES+2 cycles.
5. Assert rstz=0 during WAIT of a write to 0x30 holding 32'h11111111. Required: ack, rd_data, and state reset immediately, and a later read of 0x30 returns 32'h11111111.
6. With KRONOS_DMEM_BUSERR_EN, write 32'hFFFFFFFF to BASE_ADDR+DEPTH*4. Required: ack with data_err=1 and word 0 unchanged. Without the macro, the same write lands in word 0.

Source files
------------

// File: rtl/kronos_dmem_responder_pkg.sv
// Shared types for the Kronos data-memory responder.
// Holds the responder FSM state encoding and wait-counter width.
package kronos_types;

  localparam int DMEM_WAIT_W = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_ACK
  } dmem_state_e;

endpackage

// File: rtl/kronos_dmem_responder_if.sv
// Kronos data-memory bus: addr/wr_data/mask/wr_en/req from the core,
// rd_data/ack (and data_err with KRONOS_DMEM_BUSERR_EN) from memory.
interface kronos_dmem_if;

  logic [31:0] data_addr;
  logic [31:0] data_rd_data;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_ack;
`ifdef KRONOS_DMEM_BUSERR_EN
  logic        data_err;

  modport master (
    output data_addr, data_wr_data, data_mask,
    output data_wr_en, data_req,
    input  data_rd_data, data_ack, data_err
  );

  modport slave (
    input  data_addr, data_wr_data, data_mask,
    input  data_wr_en, data_req,
    output data_rd_data, data_ack, data_err
  );
`else
  modport master (
    output data_addr, data_wr_data, data_mask,
    output data_wr_en, data_req,
    input  data_rd_data, data_ack
  );

  modport slave (
    input  data_addr, data_wr_data, data_mask,
    input  data_wr_en, data_req,
    output data_rd_data, data_ack
  );
`endif

endinterface

// File: rtl/kronos_dmem_responder_array.sv
// DEPTH x 32-bit single-port RAM, per-byte write enables, registered read.
// Ports: clk, rst_n, en, we, be, addr, wdata, rzero, rdata.
module kronos_dmem_array
  import kronos_types::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  input  logic                     rzero,
  output logic [31:0]              rdata
);

  logic [3:0][7:0] mem [DEPTH];
  logic [31:0]     rdata_d;
  logic [31:0]     rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register only moves on a read access; it holds otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = rzero ? 32'h0 : mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= 32'h0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/kronos_dmem_responder.sv
// Kronos data-memory responder: req capture, WAIT_CYCLES wait, 1-cycle ack.
// Ports: clk, rstz, bus (slave). KRONOS_DMEM_BUSERR_EN adds data_err.
module kronos_dmem_responder
  import kronos_types::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input logic         clk,
  input logic         rstz,
  kronos_dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
  localparam logic [DMEM_WAIT_W-1:0] CNT_INIT =
    DMEM_WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_e            state_q, state_d;
  logic [DMEM_WAIT_W-1:0] cnt_q, cnt_d;
  logic [29:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             mask_q, mask_d;
  logic                   we_q, we_d;

  logic                   cmt;
  logic [29:0]            c_addr;
  logic [31:0]            c_wdata;
  logic [3:0]             c_mask;
  logic                   c_we;
  logic [AW-1:0]          idx;
  logic                   oob;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    we_d    = we_q;
    cmt     = 1'b0;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_mask  = mask_q;
    c_we    = we_q;
    unique case (state_q)
      DMEM_IDLE: begin
        if (bus.data_req) begin
          addr_d  = bus.data_addr[31:2];
          wdata_d = bus.data_wr_data;
          mask_d  = bus.data_mask;
          we_d    = bus.data_wr_en;
          if (WAIT_CYCLES == 0) begin
            // Zero wait: commit straight from the bus on the capture edge.
            state_d = DMEM_ACK;
            cmt     = 1'b1;
            c_addr  = bus.data_addr[31:2];
            c_wdata = bus.data_wr_data;
            c_mask  = bus.data_mask;
            c_we    = bus.data_wr_en;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DMEM_ACK;
          cmt     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DMEM_ACK: state_d = DMEM_IDLE;
      default:  state_d = DMEM_IDLE;
    endcase
  end

  // BASE_ADDR is DEPTH*4 aligned, so the word offset's low bits are the index.
  assign idx = AW'(c_addr - BASE_W);

`ifdef KRONOS_DMEM_BUSERR_EN
  logic err_q, err_d;

  assign oob   = (c_addr - BASE_W) >= 30'(DEPTH);
  assign err_d = cmt & oob;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.data_err = err_q;
`else
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      we_q    <= we_d;
    end
  end

  // An out-of-range access is turned into a zeroing read: no write lands.
  kronos_dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rstz),
    .en    (cmt),
    .we    (c_we & ~oob),
    .be    (c_mask),
    .addr  (idx),
    .wdata (c_wdata),
    .rzero (oob),
    .rdata (bus.data_rd_data)
  );

  assign bus.data_ack = (state_q == DMEM_ACK);

endmodule

// File: tb/tb_kronos_dmem_responder.sv
// Scoreboard bench for kronos_dmem_responder: two instances, 0 and 3 waits,
// random traffic against a word/byte array reference model.
module tb_kronos_dmem_responder;

  localparam int          D  = 64;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0000_2000;
  localparam int          W0 = 0;
  localparam int          W1 = 3;

  logic clk = 1'b0;
  logic rstz;
  always #5 clk = ~clk;

  kronos_dmem_if b0 ();
  kronos_dmem_if b1 ();

  kronos_dmem_responder #(
    .DEPTH (D), .BASE_ADDR (B0), .WAIT_CYCLES (W0)
  ) u0 (
    .clk (clk), .rstz (rstz), .bus (b0)
  );

  kronos_dmem_responder #(
    .DEPTH (D), .BASE_ADDR (B1), .WAIT_CYCLES (W1)
  ) u1 (
    .clk (clk), .rstz (rstz), .bus (b1)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          t;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mm [2][D];
  logic [31:0] last [2];
  int          ackc [2];
  logic        prev_ack [2];
  logic [31:0] prev_rd [2];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic get_ack(int d);
    return (d == 0) ? b0.data_ack : b1.data_ack;
  endfunction

  function automatic logic [31:0] get_rd(int d);
    return (d == 0) ? b0.data_rd_data : b1.data_rd_data;
  endfunction

  function automatic logic get_err(int d);
`ifdef KRONOS_DMEM_BUSERR_EN
    return (d == 0) ? b0.data_err : b1.data_err;
`else
    return (d == 0) ? 1'b0 : 1'b0;
`endif
  endfunction

  task automatic drive(int d, logic req, logic we, logic [31:0] a,
                       logic [31:0] wd, logic [3:0] m);
    if (d == 0) begin
      b0.data_req = req; b0.data_wr_en = we; b0.data_addr = a;
      b0.data_wr_data = wd; b0.data_mask = m;
    end else begin
      b1.data_req = req; b1.data_wr_en = we; b1.data_addr = a;
      b1.data_wr_data = wd; b1.data_mask = m;
    end
  endtask

  // Reference: memory is an array of words; bytes picked by mask.
  function automatic exp_t model(int d, logic we, logic [31:0] a,
                                 logic [31:0] wd, logic [3:0] m);
    exp_t        e;
    logic [31:0] base;
    logic [31:0] off;
    int          idx;
    base  = (d == 0) ? B0 : B1;
    off   = a - base;
    idx   = int'((off / 4) % D);
    e.err = 1'b0;
    e.t   = cyc;
`ifdef KRONOS_DMEM_BUSERR_EN
    if (off >= D * 4) begin
      e.err   = 1'b1;
      last[d] = 32'h0;
      e.rd    = 32'h0;
      return e;
    end
`endif
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) mm[d][idx][8*i +: 8] = wd[8*i +: 8];
    end else begin
      last[d] = mm[d][idx];
    end
    e.rd = last[d];
    return e;
  endfunction

  task automatic xfer(int d, logic we, logic [31:0] a,
                      logic [31:0] wd, logic [3:0] m);
    exp_t e;
    bit   got;
    e = model(d, we, a, wd, m);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    drive(d, 1'b1, we, a, wd, m);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (get_ack(d)) got = 1'b1;
    end
    if (!got) chk("ack_timeout", 32'(got), 32'd1);
    drive(d, 1'b0, $urandom, $urandom, $urandom, 4'($urandom));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        ack;
      logic [31:0] rd;
      exp_t        e;
      bit          have;
      ack  = get_ack(d);
      rd   = get_rd(d);
      have = 1'b0;
      if (rstz) begin
        if (ack) begin
          chk("single_cycle_ack", 32'(prev_ack[d]), 32'd0);
          ackc[d] = cyc;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (!have) begin
            chk("unexpected_ack", 32'(d), 32'hFFFF_FFFF);
          end else begin
            chk("rd_data", rd, e.rd);
            chk("data_err", 32'(get_err(d)), 32'(e.err));
            chk("latency", 32'(cyc - e.t), 32'(1 + ((d == 0) ? W0 : W1)));
          end
        end else if (prev_rd[d] !== 32'hx) begin
          chk("rd_hold", rd, prev_rd[d]);
        end
      end
      prev_ack[d] = ack;
      prev_rd[d]  = rd;
    end
  end

  initial begin
    int          t1;
    logic [31:0] base;
    rstz = 1'b0;
    last[0] = 32'h0;
    last[1] = 32'h0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ack", 32'(get_ack(d)), 32'd0);
      chk("reset_rd", get_rd(d), 32'h0);
      chk("reset_err", 32'(get_err(d)), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 rstz = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      base = (d == 0) ? B0 : B1;
      for (int i = 0; i < D; i++)
        xfer(d, 1'b1, base + 32'(4 * i), $urandom, 4'hF);
    end

    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("t1_rd", get_rd(0), 32'hDEADBEEF);
    xfer(0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010);
    xfer(0, 1'b0, 32'h12, 32'h0, 4'hF);
    chk("t2_rd", get_rd(0), 32'hDEADAAEF);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h1);
    chk("t2_rd_mask1", get_rd(0), 32'hDEADAAEF);
    xfer(0, 1'b1, 32'h10, 32'h12345678, 4'h0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("mask0_rd", get_rd(0), 32'hDEADAAEF);

    for (int d = 0; d < 2; d++) begin
      base = (d == 0) ? B0 : B1;
      xfer(d, 1'b1, base + 32'h20, 32'hCAFE0000 + 32'(d), 4'hF);
      t1 = ackc[d];
      xfer(d, 1'b0, base + 32'h20, 32'h0, 4'h0);
      chk("b2b_spacing", 32'(ackc[d] - t1), 32'(((d == 0) ? W0 : W1) + 2));
      chk("b2b_rd", get_rd(d), 32'hCAFE0000 + 32'(d));
    end

    xfer(1, 1'b1, B1 + 32'h30, 32'h11111111, 4'hF);
    drive(1, 1'b1, 1'b1, B1 + 32'h30, 32'h22222222, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstz = 1'b0;
    #1;
    chk("abort_ack", 32'(get_ack(1)), 32'd0);
    chk("abort_rd", get_rd(1), 32'h0);
    last[0] = 32'h0;
    last[1] = 32'h0;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    rstz = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, B1 + 32'h30, 32'h0, 4'h0);
    chk("abort_no_write", get_rd(1), 32'h11111111);

    xfer(1, 1'b1, B1 + 32'h0, 32'h0BADF00D, 4'hF);
    xfer(1, 1'b1, B1 + 32'(D * 4), 32'hFFFFFFFF, 4'hF);
    xfer(1, 1'b0, B1, 32'h0, 4'h0);
`ifdef KRONOS_DMEM_BUSERR_EN
    chk("oob_word0", get_rd(1), 32'h0BADF00D);
`else
    chk("wrap_word0", get_rd(1), 32'hFFFFFFFF);
`endif

    for (int n = 0; n < 120; n++) begin
      int          d;
      logic [31:0] a;
      d    = n % 2;
      base = (d == 0) ? B0 : B1;
      a    = base + $urandom_range(0, D * 8 - 1);
      if (d == 1 && ($urandom % 8) == 0)
        a = base - 32'(4 * $urandom_range(1, 8));
      xfer(d, 1'($urandom), a, $urandom, 4'($urandom));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
